// File: rtl/adc_scan_ctrl.sv
// Round-robin scan controller for ADC0809-class converters: free-running converter clock,
// ALE/START/OE handshake, EOC timeout recovery. Define ADC_SCAN_AVG_EN for 4-sample averaging.
module adc_scan_ctrl #(
  parameter int CLK_DIV = 26,
  parameter int N_CH    = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int T_ALE   = 2,
  parameter int T_START = 6,
  parameter int T_OE    = 10,
  parameter int EOC_TO  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic              eoc,
  input  logic [DATA_W-1:0] result,
  output logic              adc_clk,
  output logic [ADDR_W-1:0] addr,
  output logic              ale,
  output logic              start,
  output logic              out_en,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] data_ch,
  output logic              data_valid,
  output logic              scan_done,
  output logic              timeout_err
);
  localparam int DIV_W  = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
  localparam int T_M1   = (T_ALE > T_START) ? T_ALE : T_START;
  localparam int T_M2   = (T_M1 > T_OE) ? T_M1 : T_OE;
  localparam int T_MAX  = (T_M2 > EOC_TO) ? T_M2 : EOC_TO;
  localparam int CNT_W  = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_ALE, S_START, S_WAIT_LO, S_WAIT_HI, S_OE, S_CAPTURE, S_NEXT
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic              adc_clk_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q, data_ch_q;
  logic [DATA_W-1:0] data_q;
  logic              ale_q, start_q, out_en_q, data_valid_q, scan_done_q, timeout_err_q;
  logic [ADDR_W-1:0] first_ch_d, next_ch_d;
  logic              wrap_d;

  // Converter clock is independent of the scan state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q     <= '0;
      adc_clk_q <= 1'b0;
    end else if (div_q == DIV_W'(CLK_DIV)) begin
      div_q     <= '0;
      adc_clk_q <= ~adc_clk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Lowest set bit at/above and strictly above the pointer; fall back to the lowest set bit.
  logic [ADDR_W-1:0] lo_ch, ge_ch, gt_ch;
  logic              found_ge, found_gt;
  always_comb begin
    lo_ch    = '0;
    ge_ch    = '0;
    gt_ch    = '0;
    found_ge = 1'b0;
    found_gt = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        lo_ch = ADDR_W'(i);
        if (i >= int'(ptr_q)) begin
          ge_ch    = ADDR_W'(i);
          found_ge = 1'b1;
        end
        if (i > int'(ptr_q)) begin
          gt_ch    = ADDR_W'(i);
          found_gt = 1'b1;
        end
      end
    end
    first_ch_d = found_ge ? ge_ch : lo_ch;
    next_ch_d  = found_gt ? gt_ch : lo_ch;
    wrap_d     = !found_gt;
  end

`ifdef ADC_SCAN_AVG_EN
  logic [DATA_W+1:0] acc_q;
  logic [DATA_W+1:0] acc_sum;
  logic [1:0]        avg_q;
  assign acc_sum = acc_q + {2'b00, result};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      ptr_q         <= '0;
      addr_q        <= '0;
      ale_q         <= 1'b0;
      start_q       <= 1'b0;
      out_en_q      <= 1'b0;
      data_q        <= '0;
      data_ch_q     <= '0;
      data_valid_q  <= 1'b0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      acc_q         <= '0;
      avg_q         <= '0;
`endif
    end else begin
      data_valid_q  <= 1'b0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (enable && ch_mask != '0) begin
          ptr_q   <= first_ch_d;
          addr_q  <= first_ch_d;
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          ale_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_ALE;
        end
        S_ALE: if (cnt_q == CNT_W'(T_ALE - 1)) begin
          ale_q   <= 1'b0;
          start_q <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_START;
        end else cnt_q <= cnt_q + 1'b1;
        S_START: if (cnt_q == CNT_W'(T_START - 1)) begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT_LO;
        end else cnt_q <= cnt_q + 1'b1;
        S_WAIT_LO, S_WAIT_HI: begin
          if (eoc == (state_q == S_WAIT_HI)) begin
            cnt_q    <= '0;
            out_en_q <= (state_q == S_WAIT_HI);
            state_q  <= (state_q == S_WAIT_HI) ? S_OE : S_WAIT_HI;
          end else if (cnt_q == CNT_W'(EOC_TO - 1)) begin
            // Stuck converter: abandon this channel and move on.
            timeout_err_q <= 1'b1;
            state_q       <= S_NEXT;
`ifdef ADC_SCAN_AVG_EN
            acc_q         <= '0;
            avg_q         <= '0;
`endif
          end else cnt_q <= cnt_q + 1'b1;
        end
        S_OE: if (cnt_q == CNT_W'(T_OE - 1)) begin
          out_en_q <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
          if (avg_q == 2'd3) begin
            data_q       <= acc_sum[DATA_W+1:2];
            data_ch_q    <= ptr_q;
            data_valid_q <= 1'b1;
            acc_q        <= '0;
            avg_q        <= '0;
            state_q      <= S_CAPTURE;
          end else begin
            acc_q   <= acc_sum;
            avg_q   <= avg_q + 2'd1;
            state_q <= S_SETUP;
          end
`else
          data_q       <= result;
          data_ch_q    <= ptr_q;
          data_valid_q <= 1'b1;
          state_q      <= S_CAPTURE;
`endif
        end else cnt_q <= cnt_q + 1'b1;
        S_CAPTURE: state_q <= S_NEXT;
        S_NEXT: begin
          scan_done_q <= wrap_d;
          if (ch_mask != '0) ptr_q <= next_ch_d;
          if (enable && ch_mask != '0) begin
            addr_q  <= next_ch_d;
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_clk     = adc_clk_q;
  assign addr        = addr_q;
  assign ale         = ale_q;
  assign start       = start_q;
  assign out_en      = out_en_q;
  assign data        = data_q;
  assign data_ch     = data_ch_q;
  assign data_valid  = data_valid_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: behavioural ADC0809 model, scoreboard of expected samples,
// table of mask scenarios plus reset, timeout, stop and (if enabled) averaging sequences.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       eoc = 1'b1;
  logic [7:0] result = 8'h00;
  logic       adc_clk, ale, start, out_en, data_valid, scan_done, timeout_err;
  logic [2:0] addr, data_ch;
  logic [7:0] data;

  always #5 clk = ~clk;

  adc_scan_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .eoc(eoc),
    .result(result), .adc_clk(adc_clk), .addr(addr), .ale(ale), .start(start),
    .out_en(out_en), .data(data), .data_ch(data_ch), .data_valid(data_valid),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [7:0]      mask;
    logic [3:0]      n;
    logic [8:0][2:0] chs;
    logic [8:0]      dones;
  } vec_t;

  exp_t sb_q[$];
  vec_t vec[6];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  bit   done_pending = 0, to_expected = 0, eoc_stuck = 0, avg_mode = 0;
  int   to_seen = 0, ale_rises = 0, lo_cnt = 0;
  int   ale_w = 0, start_w = 0, oe_w = 0, eoc_timer = 0, avg_seq = 0;
  logic p_ale = 0, p_start = 0, p_oe = 0, m_pstart = 0, m_poe = 0;
  logic [2:0] addr_lat = '0;
  bit   in_conv = 0, addr_bad = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Converter model: EOC drops 2 cycles after START falls, rises 20 later.
  always @(negedge clk) begin
    if (!reset || eoc_stuck) begin
      eoc = 1'b1;
      eoc_timer = 0;
    end else begin
      if (m_pstart && !start) eoc_timer = 1;
      else if (eoc_timer > 0) eoc_timer++;
      if (eoc_timer == 2) eoc = 1'b0;
      if (eoc_timer == 22) begin
        eoc = 1'b1;
        eoc_timer = 0;
      end
    end
    m_pstart = start;
    if (!reset) avg_seq = 0;
    else if (m_poe && !out_en) avg_seq++;
    m_poe = out_en;
    result = avg_mode ? 8'(10 + avg_seq) : {1'b0, addr, 4'h3};
  end

  // Protocol monitor and scoreboard consumer.
  always @(negedge clk) begin
    if (!reset) begin
      p_ale = 0; p_start = 0; p_oe = 0;
      ale_w = 0; start_w = 0; oe_w = 0; in_conv = 0;
    end else begin
      if (ale && !p_ale) begin
        ale_rises++;
        addr_lat = addr;
        in_conv  = 1;
        addr_bad = 0;
      end
      if (in_conv && addr !== addr_lat) addr_bad = 1;
      if (ale) ale_w++;
      else if (p_ale) begin check_eq("ale_width", ale_w, 2); ale_w = 0; end
      if (start) start_w++;
      else if (p_start) begin check_eq("start_width", start_w, 6); start_w = 0; end
      if (p_start && !start) lo_cnt = 1; else lo_cnt++;
      if (out_en) oe_w++;
      else if (p_oe) begin
        check_eq("out_en_width", oe_w, 10);
        check_eq("addr_stable", int'(addr_bad), 0);
        oe_w = 0;
        in_conv = 0;
      end
      if (data_valid) begin
        check_eq("dv_after_last_oe", int'(p_oe), 1);
        check_eq("dv_no_other_strobe", int'({scan_done, timeout_err}), 0);
        if (sb_q.size() == 0) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL unexpected_data_valid: got ch %0d data %0h, expected none", data_ch, data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("data", int'(data), int'(e.data));
          check_eq("data_ch", int'(data_ch), int'(e.ch));
          check_eq("scan_done_missed", int'(done_pending), 0);
          done_pending = e.done;
          $display("sample ch=%0d data=%02h exp_ch=%0d exp_data=%02h", data_ch, data, e.ch, e.data);
        end
      end
      if (scan_done) begin
        check_eq("scan_done_expected", int'(done_pending), 1);
        done_pending = 0;
      end
      if (timeout_err) begin
        check_eq("timeout_expected", int'(to_expected), 1);
        check_eq("timeout_wait_lo_cycles", lo_cnt, 256);
        to_seen++;
      end
      p_ale = ale; p_start = start; p_oe = out_en;
    end
  end

  task automatic apply_reset();
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs_zero",
             int'({adc_clk, addr, ale, start, out_en, data, data_ch, data_valid, scan_done, timeout_err}), 0);
    sb_q.delete();
    done_pending = 0;
    to_expected  = 0;
    reset = 1'b1;
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [7:0] d, input logic dn);
    sb_q.push_back('{ch: c, data: d, done: dn});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || done_pending) && n < budget) begin
      @(negedge clk);
      n++;
    end
    cmp_cnt++;
    if (n >= budget) begin
      err_cnt++;
      $display("FAIL %s_drain: %0d samples outstanding after %0d cycles, expected 0", name, sb_q.size(), budget);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, n, r0, t0;
    logic pclk;
    vec[0] = '{8'hFF, 4'd9, {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 9'b0_1000_0000};
    vec[1] = '{8'h84, 4'd4, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd2, 3'd7, 3'd2}, 9'b0_0000_1010};
    vec[2] = '{8'h01, 4'd3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 9'b0_0000_0111};
    vec[3] = '{8'h80, 4'd2, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7}, 9'b0_0000_0011};
    vec[4] = '{8'h22, 4'd3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd1}, 9'b0_0000_0010};
    vec[5] = '{8'h60, 4'd3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd6, 3'd5}, 9'b0_0000_0010};

    // Reset with enable held high, then converter clock phase and period.
    reset = 1'b0; enable = 1'b1; ch_mask = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs_zero",
             int'({adc_clk, addr, ale, start, out_en, data, data_ch, data_valid, scan_done, timeout_err}), 0);
    reset = 1'b1; enable = 1'b0;
    first = 0; second = 0; pclk = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (adc_clk && !pclk) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      pclk = adc_clk;
    end
    check_eq("adc_clk_first_rise", first, 27);
    check_eq("adc_clk_period", second - first, 54);
    $display("adc_clk first_rise=%0d period=%0d", first, second - first);

    // Mask scenarios from the table.
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      ch_mask = vec[r].mask;
      for (int k = 0; k < int'(vec[r].n); k++) begin
        logic [2:0] c;
        c = vec[r].chs[k];
        push_exp(c, {1'b0, c, 4'h3}, vec[r].dones[k]);
      end
      enable = 1'b1;
      wait_drain(8000, "mask_row");
    end

    // Empty mask stays idle; a later non-empty mask starts the scan.
    apply_reset();
    ch_mask = 8'h00; enable = 1'b1;
    r0 = ale_rises;
    repeat (60) @(negedge clk);
    check_eq("mask_zero_no_ale", ale_rises - r0, 0);
    push_exp(3'd3, 8'h33, 1'b1);
    ch_mask = 8'h08;
    wait_drain(2000, "mask_late");

    // EOC stuck high: timeout on ch0, then ch1 converts normally.
    apply_reset();
    eoc_stuck = 1; to_expected = 1; ch_mask = 8'h03; enable = 1'b1;
    t0 = to_seen; n = 0;
    while (to_seen == t0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    eoc_stuck = 0; to_expected = 0;
    check_eq("timeout_pulses", to_seen - t0, 1);
    push_exp(3'd1, 8'h13, 1'b1);
    wait_drain(2000, "timeout_next");

    // Enable dropped during START of ch3: ch3 completes, then idle.
    apply_reset();
    ch_mask = 8'hFF;
    for (int k = 0; k < 4; k++) push_exp(3'(k), {1'b0, 3'(k), 4'h3}, 1'b0);
    enable = 1'b1;
    n = 0;
    while (!(start && addr == 3'd3) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    check_eq("stop_reached_ch3_start", int'(start && addr == 3'd3), 1);
    enable = 1'b0;
    wait_drain(2000, "stop");
    r0 = ale_rises;
    repeat (150) @(negedge clk);
    check_eq("stop_no_ale", ale_rises - r0, 0);

`ifdef ADC_SCAN_AVG_EN
    // Results 10,11,12,13 on ch0 average to 11.
    apply_reset();
    avg_mode = 1; ch_mask = 8'h01;
    push_exp(3'd0, 8'd11, 1'b1);
    enable = 1'b1;
    wait_drain(2000, "avg");
    avg_mode = 0;
`endif

    apply_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Parametrised multi-channel scan controller for ADC0809-class successive-approximation converters with a multiplexed input. It generates the converter clock and drives the address/ALE/START/OE handshake. It walks a programmable channel mask in round-robin order and streams each captured sample, tagged with its channel, to downstream logic. It supersedes the fixed single-channel controller, adding a channel mask, EOC timeout recovery, scan-complete signalling and optional averaging.

## Interface
Parameters:
- CLK_DIV, 26: adc_clk half-period minus one, in clk cycles
- N_CH, 8: number of converter channels (2..8)
- ADDR_W, 3: address width, clog2(N_CH)
- DATA_W, 8: converter result width
- T_ALE, 2: cycles ale is high
- T_START, 6: cycles start is high
- T_OE, 10: cycles out_en is high before capture
- EOC_TO, 255: max cycles spent waiting on either EOC edge

Ports:
- clk  in  1  system clock
- reset  in  1  active-low synchronous reset
- enable  in  1  scan run request
- ch_mask  in  N_CH  channel enable mask, bit i = channel i
- eoc  in  1  converter end-of-conversion
- result  in  DATA_W  converter data bus
- adc_clk  out  1  converter clock
- addr  out  ADDR_W  converter mux address
- ale  out  1  address latch enable
- start  out  1  conversion start
- out_en  out  1  converter output enable
- data  out  DATA_W  captured sample
- data_ch  out  ADDR_W  channel of data
- data_valid  out  1  one-cycle sample strobe
- scan_done  out  1  one-cycle strobe after last enabled channel
- timeout_err  out  1  one-cycle strobe on EOC timeout

One clock; reset is synchronous and active-low.

## Operation
- Reset (reset=0 sampled at a clk edge): all outputs 0, state IDLE, divider 0, channel pointer 0. This applies mid-conversion too, with no completion.
- adc_clk: divider counts 0..CLK_DIV and toggles adc_clk on wrap. It is free-running regardless of state, with period 2*(CLK_DIV+1) clk.
- State IDLE: all strobes 0. Leave when enable=1 and ch_mask!=0. The first channel is the lowest set bit ≥ pointer.
- SETUP (1 cycle): addr driven with the channel and held stable through OE.
- ALE (T_ALE cycles): ale=1.
- START (T_START cycles): start=1, ale=0.
- WAIT_LO: wait for eoc=0.
- WAIT_HI: wait for eoc=1.
- Each wait state has its own counter. On reaching EOC_TO cycles: pulse timeout_err, produce no data_valid, go to NEXT.
- OE (T_OE cycles): out_en=1. result is sampled on the last OE cycle.
- CAPTURE (1 cycle): data/data_ch updated, data_valid=1, out_en=0.
- NEXT (1 cycle):
  - Advance the pointer to the next set bit of ch_mask (current value), ascending, wrapping past N_CH-1 to 0.
  - If the wrap occurs, or no higher bit is set, pulse scan_done.
  - Go to SETUP if enable=1 and mask!=0, else IDLE.
- enable deasserted mid-conversion: the conversion finishes through NEXT, then IDLE.
- ch_mask is sampled only in IDLE and NEXT.
- Single-bit mask: the same channel is repeated, and scan_done pulses on every NEXT.
- data/data_ch hold between strobes.

## Timing
- Conversion latency is 1+T_ALE+T_START+w_lo+w_hi+T_OE+1+1 cycles, where w_lo/w_hi are the wait-state occupancies (≥1 each).
- With defaults and immediate EOC response, one channel takes 23 cycles.
- data_valid is asserted the cycle after the last out_en cycle.
- scan_done and timeout_err are never asserted in the same cycle as data_valid.
- All outputs are registered.

## Configuration
- ADC_SCAN_AVG_EN defined: each channel is converted 4 times consecutively before NEXT. Samples are summed in a DATA_W+2 accumulator. data = sum[DATA_W+1:2], and data_valid fires only after the 4th sample. A timeout clears the accumulator and abandons the channel.
- ADC_SCAN_AVG_EN undefined: one conversion per channel and no accumulator logic.

## Test plan
- Reset: hold reset=0 for 3 cycles with enable=1 -> all outputs 0. The first adc_clk rise is 27 cycles after release, and the period is 54.
- Full scan: mask=8'hFF, eoc model drops 2 cycles after start falls and rises 20 later, result=ch*16+3 -> data_valid sequence ch0..7 with data 03,13,…,73. scan_done occurs after ch7, then wraps to ch0.
- Sparse mask: mask=8'b1000_0100 -> channels 2,7,2,7…. addr is stable from SETUP through OE, and ale/start widths are 2/6 cycles.
- Timeout: eoc held 1 -> timeout_err after 255 WAIT_LO cycles, no data_valid, and the next channel proceeds.
- Stop: enable dropped during START of ch3 -> ch3 data_valid still occurs, then IDLE with no further ale.
- With ADC_SCAN_AVG_EN: result sequence 10,11,12,13 on ch0 -> a single data_valid with data=11 (46>>2).
